// File: rtl/fsm_mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fsm_mult_result_collector
// Description : Captures fixed-latency multiply results into a show-ahead
//               FIFO and returns credit back-pressure to the issue side.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_mult_result_collector #(
   parameter int W     = 32,
   parameter int LAT   = 4,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue_in,
   output logic         issue_ready,
   input  logic [W-1:0] pipe_result,
   output logic [W-1:0] result_out,
   output logic         result_valid,
   input  logic         result_ack,
   output logic         busy,
   output logic         issue_err
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;
   localparam logic [c_CW:0] c_DEPTH_S = (c_CW + 1)'(DEPTH);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FILL  = 2'd1;
   localparam logic [1:0] c_STALL = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   logic [LAT-1:0]  r_vsr;
   logic [c_CW-1:0] r_in_flight;
   logic [c_CW-1:0] r_count;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [W-1:0]    r_mem [DEPTH];
   logic [1:0]      r_state;
   logic            r_issue_err;

   logic            w_acc;
   logic            w_retire;
   logic            w_rd;
   logic [c_CW-1:0] w_if_nxt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic [c_CW:0]   w_sum;
   logic [c_CW:0]   w_sum_nxt;
   logic [1:0]      w_state_nxt;

   // Credits depend on registered counters only, so result_ack never
   // reaches issue_ready combinationally.
   assign w_sum        = {1'b0, r_in_flight} + {1'b0, r_count};
   assign issue_ready  = (w_sum < c_DEPTH_S);
   assign w_acc        = issue_in & issue_ready;
   assign w_retire     = r_vsr[LAT-1];
   assign result_valid = (r_count != '0);
   assign w_rd         = result_ack & result_valid;
   assign result_out   = r_mem[r_rd_ptr];
   assign busy         = (r_state != c_IDLE);
   assign issue_err    = r_issue_err;

   generate
      if (LAT == 1) begin : g_vsr_single
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_vsr <= '0;
            else      r_vsr <= w_acc;
         end
      end else begin : g_vsr_shift
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) r_vsr <= '0;
            else      r_vsr <= {r_vsr[LAT-2:0], w_acc};
         end
      end
   endgenerate

   always_comb begin
      w_if_nxt = r_in_flight;
      if (w_acc && !w_retire)
         w_if_nxt = r_in_flight + 1'b1;
      else if (!w_acc && w_retire)
         w_if_nxt = r_in_flight - 1'b1;
   end

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_retire && !w_rd)
         w_cnt_nxt = r_count + 1'b1;
      else if (!w_retire && w_rd)
         w_cnt_nxt = r_count - 1'b1;
   end

   assign w_sum_nxt = {1'b0, w_if_nxt} + {1'b0, w_cnt_nxt};

   // The state is a pure function of the next occupancy, evaluated in
   // priority order IDLE, STALL, DRAIN, FILL.
   always_comb begin
      w_state_nxt = c_FILL;
      if (w_sum_nxt == '0)
         w_state_nxt = c_IDLE;
      else if (w_sum_nxt == c_DEPTH_S)
         w_state_nxt = c_STALL;
      else if ((w_if_nxt == '0) && (w_cnt_nxt != '0) && !w_acc)
         w_state_nxt = c_DRAIN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_flight <= '0;
         r_count     <= '0;
         r_state     <= c_IDLE;
         r_issue_err <= 1'b0;
      end else begin
         r_in_flight <= w_if_nxt;
         r_count     <= w_cnt_nxt;
         r_state     <= w_state_nxt;
         if (issue_in && !issue_ready)
            r_issue_err <= 1'b1;
      end
   end

   // Memory is reset so the head reads zero straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_retire) begin
            r_mem[r_wr_ptr] <= pipe_result;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_rd)
            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fsm_mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_mult_result_collector
// Description : Scoreboard bench with a cycle model of pipeline and credits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_mult_result_collector;

   localparam int W     = 32;
   localparam int LAT   = 4;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst;
   logic         issue_in;
   logic         issue_ready;
   logic [W-1:0] pipe_result;
   logic [W-1:0] result_out;
   logic         result_valid;
   logic         result_ack;
   logic         busy;
   logic         issue_err;

   int n_checks;
   int n_errors;

   // Cycle model: pipeline slots, occupancy counters and expected results.
   logic         m_pv [LAT];
   logic [W-1:0] m_pd [LAT];
   int           m_if;
   int           m_cnt;
   logic         m_err;
   logic [W-1:0] sb [$];
   int           n_acc;

   fsm_mult_result_collector #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .issue_in     (issue_in),
      .issue_ready  (issue_ready),
      .pipe_result  (pipe_result),
      .result_out   (result_out),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .busy         (busy),
      .issue_err    (issue_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic m_ready();
      return (m_if + m_cnt) < DEPTH;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LAT; i++) m_pv[i] = 1'b0;
      m_if  = 0;
      m_cnt = 0;
      m_err = 1'b0;
      sb.delete();
   endtask

   task automatic check_outputs();
      check_value("issue_ready", 32'(issue_ready), 32'(m_ready()));
      check_value("result_valid", 32'(result_valid), 32'(m_cnt != 0));
      check_value("busy", 32'(busy), 32'((m_if + m_cnt) != 0));
      check_value("issue_err", 32'(issue_err), 32'(m_err));
      if (m_cnt != 0)
         check_value("result_out", result_out, sb[0]);
   endtask

   // One clock cycle: check the DUT, drive inputs, then advance the model
   // to the state expected after the coming rising edge.
   task automatic step(input logic iss, input logic [W-1:0] d, input logic ack);
      logic acc, ret, rd;
      @(negedge clk);
      check_outputs();
      issue_in    = iss;
      result_ack  = ack;
      pipe_result = m_pd[LAT-1];
      acc = iss & m_ready();
      ret = m_pv[LAT-1];
      rd  = ack & (m_cnt != 0);
      if (iss && !m_ready()) m_err = 1'b1;
      if (rd) void'(sb.pop_front());
      if (acc) begin
         sb.push_back(d);
         n_acc++;
      end
      m_if  = m_if + int'(acc) - int'(ret);
      m_cnt = m_cnt + int'(ret) - int'(rd);
      for (int i = LAT - 1; i > 0; i--) begin
         m_pv[i] = m_pv[i-1];
         m_pd[i] = m_pd[i-1];
      end
      m_pv[0] = acc;
      m_pd[0] = acc ? d : W'($urandom);
   endtask

   task automatic check_reset_values();
      check_value("rst_issue_ready", 32'(issue_ready), 32'd1);
      check_value("rst_result_valid", 32'(result_valid), 32'd0);
      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_issue_err", 32'(issue_err), 32'd0);
      check_value("rst_result_out", result_out, 32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      n_acc       = 0;
      rst         = 1'b0;
      issue_in    = 1'b0;
      result_ack  = 1'b0;
      pipe_result = '0;
      for (int i = 0; i < LAT; i++) m_pd[i] = W'($urandom);
      model_clear();

      // Reset defaults
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_values();

      // Single op with ack one cycle after it becomes visible
      step(1'b1, 32'h40490FDB, 1'b0);
      for (int c = 1; c <= 5; c++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);

      // Back-pressure: six issue attempts, only DEPTH accepted
      for (int c = 0; c < 6; c++) step(1'b1, 32'h100 + W'(c), 1'b0);
      for (int c = 0; c < LAT; c++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Retire and ack in the same cycle with two results buffered
      step(1'b1, 32'h1, 1'b0);
      step(1'b1, 32'h2, 1'b0);
      step(1'b1, 32'h3, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0);
      for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1);
      check_value("order_drained", 32'(sb.size()), 32'd0);

      // Pointer wrap: ten accepted ops, consumer always ready
      n_acc = 0;
      for (int c = 0; c < 60 && (n_acc < 10 || sb.size() != 0); c++)
         step((n_acc < 10) && m_ready(), 32'hA000 + W'(n_acc), 1'b1);
      check_value("wrap_accepted", 32'(n_acc), 32'd10);
      check_value("wrap_drained", 32'(sb.size()), 32'd0);

      // Reset in the middle of two in-flight ops
      step(1'b1, 32'hDEAD0001, 1'b0);
      step(1'b1, 32'hDEAD0002, 1'b0);
      step(1'b0, '0, 1'b0);
      #2 rst = 1'b0;
      model_clear();
      #1 check_reset_values();
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b0);
      check_value("post_rst_valid", 32'(result_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
